// File: rtl/dmem_lsu_if.sv
// dmem_lsu_if: request/response handshake bundle between the MEM stage and the LSU.
//   master modport: MEM stage side (drives req_*, resp_ready).
//   slave modport : LSU side (drives req_ready, resp_*).
//   req_*  : valid/ready request carrying we, size, unsigned flag, byte address, store data.
//   resp_* : valid/ready response carrying formatted load data and error flag.
interface dmem_lsu_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit between the MEM stage and a word-addressed data RAM.
//   Byte/halfword/word accesses, little-endian lanes, sign/zero-extended loads,
//   sub-word stores as read-modify-write. RAM strobes are registered and never both high.
// Ports:
//   clk, rst_n       : clock (rising edge), asynchronous active-low reset
//   bus (slave)      : request/response handshake (see dmem_lsu_if)
//   DMEM_address     : RAM word index, zero-extended
//   DMEM_data_in     : RAM write data
//   DMEM_mem_write   : RAM write strobe
//   DMEM_mem_read    : RAM read strobe
//   DMEM_data_out    : RAM read data, registered by the RAM on the falling edge
// Build option: define DMEM_LSU_BOUNDS_CHECK_EN to flag addresses beyond the RAM depth as
// errors; otherwise the upper address bits are ignored and the index wraps.
module dmem_lsu #(
   parameter int unsigned ADDR_WORDS_LOG2 = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   dmem_lsu_if.slave   bus,
   output logic [31:0] DMEM_address,
   output logic [31:0] DMEM_data_in,
   output logic        DMEM_mem_write,
   output logic        DMEM_mem_read,
   input  logic [31:0] DMEM_data_out
);

`ifdef DMEM_LSU_BOUNDS_CHECK_EN
   localparam bit BoundsEn = 1'b1;
`else
   localparam bit BoundsEn = 1'b0;
`endif

   typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

   state_e      state_q, state_d;
   logic        we_q, we_d, uns_q, uns_d;
   logic [1:0]  size_q, size_d, lane_q, lane_d;
   logic [15:0] wdata_q, wdata_d;
   logic [31:0] addr_q, addr_d, data_in_q, data_in_d;
   logic        mem_write_q, mem_write_d, mem_read_q, mem_read_d;
   logic        resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;

   logic        misaligned, upper_nz, req_err;
   logic [31:0] word_idx, lane_data, load_val, lane_mask, store_val, merged;
   logic [4:0]  shamt;

   // Request decode, evaluated on the live inputs during IDLE.
   always_comb begin
      misaligned = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                   ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
      upper_nz   = |bus.req_addr[31:ADDR_WORDS_LOG2+2];
      req_err    = misaligned || (bus.req_size == 2'b11) || (BoundsEn && upper_nz);
      word_idx   = {{(32-ADDR_WORDS_LOG2){1'b0}}, bus.req_addr[ADDR_WORDS_LOG2+1:2]};
   end

   // Lane extraction for loads and lane merge for sub-word stores, on the latched request.
   always_comb begin
      shamt     = {lane_q, 3'b000};
      lane_data = DMEM_data_out >> shamt;
      unique case (size_q)
         2'b00:   load_val = {{24{~uns_q & lane_data[7]}}, lane_data[7:0]};
         2'b01:   load_val = {{16{~uns_q & lane_data[15]}}, lane_data[15:0]};
         default: load_val = lane_data;
      endcase
      if (size_q == 2'b00) begin
         lane_mask = 32'h0000_00FF << shamt;
         store_val = {24'h0, wdata_q[7:0]} << shamt;
      end else begin
         lane_mask = 32'h0000_FFFF << shamt;
         store_val = {16'h0, wdata_q} << shamt;
      end
      merged = (DMEM_data_out & ~lane_mask) | (store_val & lane_mask);
   end

   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      uns_d        = uns_q;
      size_d       = size_q;
      lane_d       = lane_q;
      wdata_d      = wdata_q;
      addr_d       = addr_q;
      data_in_d    = data_in_q;
      mem_write_d  = 1'b0;
      mem_read_d   = 1'b0;
      resp_valid_d = resp_valid_q;
      resp_err_d   = resp_err_q;
      resp_rdata_d = resp_rdata_q;
      unique case (state_q)
         StIdle: begin
            if (bus.req_valid) begin
               we_d    = bus.req_we;
               uns_d   = bus.req_unsigned;
               size_d  = bus.req_size;
               lane_d  = bus.req_addr[1:0];
               wdata_d = bus.req_wdata[15:0];
               if (req_err) begin
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
                  resp_rdata_d = 32'h0;
                  state_d      = StResp;
               end else begin
                  addr_d = word_idx;
                  if (bus.req_we && (bus.req_size == 2'b10)) begin
                     mem_write_d = 1'b1;
                     data_in_d   = bus.req_wdata;
                     state_d     = StWr;
                  end else begin
                     mem_read_d = 1'b1;
                     state_d    = StRd;
                  end
               end
            end
         end
         StRd: begin
            if (we_q) begin
               mem_write_d = 1'b1;
               data_in_d   = merged;
               state_d     = StWr;
            end else begin
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b0;
               resp_rdata_d = load_val;
               state_d      = StResp;
            end
         end
         StWr: begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b0;
            resp_rdata_d = 32'h0;
            state_d      = StResp;
         end
         StResp: begin
            if (bus.resp_ready) begin
               resp_valid_d = 1'b0;
               resp_err_d   = 1'b0;
               resp_rdata_d = 32'h0;
               state_d      = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         we_q         <= 1'b0;
         uns_q        <= 1'b0;
         size_q       <= 2'b00;
         lane_q       <= 2'b00;
         wdata_q      <= 16'h0;
         addr_q       <= 32'h0;
         data_in_q    <= 32'h0;
         mem_write_q  <= 1'b0;
         mem_read_q   <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= 32'h0;
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         uns_q        <= uns_d;
         size_q       <= size_d;
         lane_q       <= lane_d;
         wdata_q      <= wdata_d;
         addr_q       <= addr_d;
         data_in_q    <= data_in_d;
         mem_write_q  <= mem_write_d;
         mem_read_q   <= mem_read_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

   assign bus.req_ready   = (state_q == StIdle);
   assign bus.resp_valid  = resp_valid_q;
   assign bus.resp_err    = resp_err_q;
   assign bus.resp_rdata  = resp_rdata_q;
   assign DMEM_address    = addr_q;
   assign DMEM_data_in    = data_in_q;
   assign DMEM_mem_write  = mem_write_q;
   assign DMEM_mem_read   = mem_read_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed bench for dmem_lsu with a negedge-registered RAM model.
module tb_dmem_lsu;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] DMEM_address, DMEM_data_in, DMEM_data_out;
   logic        DMEM_mem_write, DMEM_mem_read;
   logic [31:0] mem [256];
   int          total = 0;
   int          bad = 0;

   dmem_lsu_if bus ();

   dmem_lsu #(.ADDR_WORDS_LOG2(8)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .bus            (bus),
      .DMEM_address   (DMEM_address),
      .DMEM_data_in   (DMEM_data_in),
      .DMEM_mem_write (DMEM_mem_write),
      .DMEM_mem_read  (DMEM_mem_read),
      .DMEM_data_out  (DMEM_data_out)
   );

   always #5 clk = ~clk;

   // RAM model: acts on the falling edge inside each strobe cycle.
   always @(negedge clk) begin
      if (DMEM_mem_write) mem[DMEM_address[7:0]] <= DMEM_data_in;
      if (DMEM_mem_read) DMEM_data_out <= mem[DMEM_address[7:0]];
   end

   // Drives one request, scrambles the request fields after accept, and records per-cycle
   // strobes (bit j = cycle after edge N+j) until the response appears, then handshakes.
   task automatic run_op(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output logic [7:0] rdm, output logic [7:0] wrm,
                         output logic both, output logic [31:0] wa, output logic [31:0] wd,
                         output logic [31:0] rdata, output logic err);
      int t;
      lat = -1; rdm = '0; wrm = '0; both = 1'b0; wa = '0; wd = '0; rdata = '0; err = 1'b0;
      @(negedge clk);
      bus.req_we = we; bus.req_size = size; bus.req_unsigned = uns;
      bus.req_addr = addr; bus.req_wdata = wdata; bus.req_valid = 1'b1;
      t = 0;
      while (!bus.req_ready && t < 20) begin @(negedge clk); t++; end
      @(posedge clk); #1;
      bus.req_valid = 1'b0; bus.req_we = ~we; bus.req_size = ~size; bus.req_unsigned = ~uns;
      bus.req_addr = ~addr; bus.req_wdata = ~wdata;
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         rdm[j] = DMEM_mem_read;
         wrm[j] = DMEM_mem_write;
         if (DMEM_mem_read && DMEM_mem_write) both = 1'b1;
         if (DMEM_mem_write) begin wa = DMEM_address; wd = DMEM_data_in; end
         if (bus.resp_valid) begin
            lat = j; rdata = bus.resp_rdata; err = bus.resp_err;
            break;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00; bus.req_unsigned = 1'b0;
      bus.req_addr = '0; bus.req_wdata = '0; bus.resp_ready = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got %b want 1", bus.req_ready); end
      total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", bus.resp_valid); end
      total++; if (bus.resp_rdata !== 32'h0 || bus.resp_err !== 1'b0) begin bad++; $display("FAIL reset_resp got %h/%b want 0/0", bus.resp_rdata, bus.resp_err); end
      total++; if ({DMEM_mem_read, DMEM_mem_write} !== 2'b00 || DMEM_address !== 32'h0 || DMEM_data_in !== 32'h0) begin bad++; $display("FAIL reset_dmem got r%b w%b a%h d%h want all 0", DMEM_mem_read, DMEM_mem_write, DMEM_address, DMEM_data_in); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_word_store;
      int lat; logic [7:0] rdm, wrm; logic both, err; logic [31:0] wa, wd, rd;
      run_op(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, rdm, wrm, both, wa, wd, rd, err);
      total++; if (lat !== 1) begin bad++; $display("FAIL wst_latency got %0d want 1", lat); end
      total++; if (rdm !== 8'h00 || wrm !== 8'h01 || both) begin bad++; $display("FAIL wst_strobes got rd %b wr %b want 00000000/00000001", rdm, wrm); end
      total++; if (wa !== 32'h4 || wd !== 32'hDEADBEEF) begin bad++; $display("FAIL wst_bus got %h/%h want 00000004/deadbeef", wa, wd); end
      total++; if (rd !== 32'h0 || err !== 1'b0) begin bad++; $display("FAIL wst_resp got %h/%b want 0/0", rd, err); end
      run_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rdm, wrm, both, wa, wd, rd, err);
      total++; if (lat !== 1 || rdm !== 8'h01 || wrm !== 8'h00) begin bad++; $display("FAIL wld_timing got lat %0d rd %b wr %b want 1/00000001/0", lat, rdm, wrm); end
      total++; if (rd !== 32'hDEADBEEF || err !== 1'b0) begin bad++; $display("FAIL wld_data got %h/%b want deadbeef/0", rd, err); end
   endtask

   task automatic test_byte_store;
      int lat; logic [7:0] rdm, wrm; logic both, err; logic [31:0] wa, wd, rd;
      run_op(1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFF_FFA5, lat, rdm, wrm, both, wa, wd, rd, err);
      total++; if (lat !== 2) begin bad++; $display("FAIL bst_latency got %0d want 2", lat); end
      total++; if (rdm !== 8'h01 || wrm !== 8'h02 || both) begin bad++; $display("FAIL bst_strobes got rd %b wr %b both %b want 00000001/00000010/0", rdm, wrm, both); end
      total++; if (wa !== 32'h4 || wd !== 32'hDEADA5EF) begin bad++; $display("FAIL bst_merge got %h/%h want 00000004/deada5ef", wa, wd); end
      run_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rdm, wrm, both, wa, wd, rd, err);
      total++; if (rd !== 32'hDEADA5EF || err !== 1'b0) begin bad++; $display("FAIL bst_readback got %h/%b want deada5ef/0", rd, err); end
      // Halfword store to the upper lane of word 5, then read it back.
      mem[5] = 32'h1122_3344;
      run_op(1'b1, 2'b01, 1'b0, 32'h16, 32'h0000_BEEF, lat, rdm, wrm, both, wa, wd, rd, err);
      total++; if (wa !== 32'h5 || wd !== 32'hBEEF3344 || lat !== 2) begin bad++; $display("FAIL hst_merge got %h/%h lat %0d want 00000005/beef3344/2", wa, wd, lat); end
   endtask

   task automatic test_loads;
      logic [1:0]  sz [5] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
      logic        us [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [31:0] ad [5] = '{32'h11, 32'h11, 32'h12, 32'h12, 32'h10};
      logic [31:0] ex [5] = '{32'hFFFFFFA5, 32'h000000A5, 32'hFFFFDEAD, 32'h0000DEAD, 32'hFFFFFFEF};
      int lat; logic [7:0] rdm, wrm; logic both, err; logic [31:0] wa, wd, rd;
      for (int i = 0; i < 5; i++) begin
         run_op(1'b0, sz[i], us[i], ad[i], 32'h0, lat, rdm, wrm, both, wa, wd, rd, err);
         total++; if (rd !== ex[i] || err !== 1'b0 || lat !== 1) begin bad++; $display("FAIL load_%0d got %h/%b lat %0d want %h/0/1", i, rd, err, lat, ex[i]); end
      end
   endtask

   task automatic test_errors;
      logic        we [3] = '{1'b0, 1'b1, 1'b0};
      logic [1:0]  sz [3] = '{2'b01, 2'b10, 2'b11};
      logic [31:0] ad [3] = '{32'h13, 32'h02, 32'h10};
      int lat; logic [7:0] rdm, wrm; logic both, err; logic [31:0] wa, wd, rd;
      for (int i = 0; i < 3; i++) begin
         run_op(we[i], sz[i], 1'b0, ad[i], 32'h5555_5555, lat, rdm, wrm, both, wa, wd, rd, err);
         total++; if (err !== 1'b1 || rd !== 32'h0 || lat !== 0) begin bad++; $display("FAIL err_%0d got err %b data %h lat %0d want 1/0/0", i, err, rd, lat); end
         total++; if (rdm !== 8'h00 || wrm !== 8'h00) begin bad++; $display("FAIL err_strobe_%0d got rd %b wr %b want 0/0", i, rdm, wrm); end
      end
      total++; if (mem[0] !== 32'h0) begin bad++; $display("FAIL err_nowrite got %h want 0", mem[0]); end
   endtask

   task automatic test_stall;
      int lat; logic [7:0] rdm, wrm; logic both, err; logic [31:0] wa, wd, rd;
      bus.resp_ready = 1'b0;
      @(negedge clk);
      bus.req_we = 1'b0; bus.req_size = 2'b10; bus.req_unsigned = 1'b0;
      bus.req_addr = 32'h10; bus.req_valid = 1'b1;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         total++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'hDEADA5EF || bus.resp_err !== 1'b0) begin bad++; $display("FAIL stall_hold_%0d got %b/%h/%b want 1/deada5ef/0", i, bus.resp_valid, bus.resp_rdata, bus.resp_err); end
         total++; if (bus.req_ready !== 1'b0 || DMEM_mem_read !== 1'b0 || DMEM_mem_write !== 1'b0) begin bad++; $display("FAIL stall_quiet_%0d got ready %b rd %b wr %b want 0/0/0", i, bus.req_ready, DMEM_mem_read, DMEM_mem_write); end
      end
      bus.resp_ready = 1'b1;
      @(posedge clk); #1;
      total++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin bad++; $display("FAIL stall_release got valid %b ready %b want 0/1", bus.resp_valid, bus.req_ready); end
      run_op(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, lat, rdm, wrm, both, wa, wd, rd, err);
      total++; if (rd !== 32'h000000DE || lat !== 1) begin bad++; $display("FAIL stall_next got %h lat %0d want 000000de/1", rd, lat); end
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      bus.req_we = 1'b1; bus.req_size = 2'b00; bus.req_unsigned = 1'b0;
      bus.req_addr = 32'h10; bus.req_wdata = 32'h33; bus.req_valid = 1'b1;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      @(posedge clk); #1;
      total++; if (DMEM_mem_write !== 1'b1) begin bad++; $display("FAIL rstmid_wr_cycle got %b want 1", DMEM_mem_write); end
      rst_n = 1'b0;
      #1;
      total++; if (DMEM_mem_write !== 1'b0 || DMEM_mem_read !== 1'b0 || bus.resp_valid !== 1'b0) begin bad++; $display("FAIL rstmid_clear got wr %b rd %b valid %b want 0/0/0", DMEM_mem_write, DMEM_mem_read, bus.resp_valid); end
      @(negedge clk); #1;
      total++; if (mem[4] !== 32'hDEADA5EF) begin bad++; $display("FAIL rstmid_mem got %h want deada5ef", mem[4]); end
      rst_n = 1'b1;
      @(negedge clk);
      total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got %b want 1", bus.req_ready); end
      repeat (3) @(negedge clk);
      total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL rstmid_noresp got %b want 0", bus.resp_valid); end
   endtask

   task automatic test_wrap;
      int lat; logic [7:0] rdm, wrm; logic both, err; logic [31:0] wa, wd, rd;
      run_op(1'b1, 2'b10, 1'b0, 32'h0, 32'h12345678, lat, rdm, wrm, both, wa, wd, rd, err);
      run_op(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, lat, rdm, wrm, both, wa, wd, rd, err);
`ifdef DMEM_LSU_BOUNDS_CHECK_EN
      total++; if (err !== 1'b1 || lat !== 0 || rdm !== 8'h00 || rd !== 32'h0) begin bad++; $display("FAIL bounds_err got err %b lat %0d rd %b data %h want 1/0/0/0", err, lat, rdm, rd); end
`else
      total++; if (err !== 1'b0 || lat !== 1 || rd !== 32'h12345678) begin bad++; $display("FAIL wrap_load got err %b lat %0d data %h want 0/1/12345678", err, lat, rd); end
`endif
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      DMEM_data_out = 32'h0;
      test_reset();
      test_word_store();
      test_byte_store();
      test_loads();
      test_errors();
      test_stall();
      test_reset_mid();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog keeps the run bounded.
   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "timeout");
   end

   // Strobe exclusivity, checked every cycle.
   always @(negedge clk) begin
      if (DMEM_mem_read && DMEM_mem_write) begin
         bad++;
         $display("FAIL strobe_excl got both high want at most one");
      end
   end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit between the MEM pipeline stage and the word-addressed data RAM. It accepts one byte, halfword or word access per request, converts byte addresses to RAM word indices, and formats load data with sign or zero extension. Sub-word stores run as read-modify-write sequences. The RAM's negedge read/write strobes are always mutually exclusive.

## Interface
- `ADDR_WORDS_LOG2`, default 8: log2 of the RAM depth in words; byte address bits `[ADDR_WORDS_LOG2+1:2]` form the word index.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low. One clock domain.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE; the request is accepted on a rising edge where valid and ready are both high.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 halfword, 10 word, 11 reserved (error).
- `req_unsigned` in 1: load zero-extends when 1, sign-extends when 0.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `resp_valid` out 1: response held until `resp_ready`.
- `resp_ready` in 1: response consumer ready.
- `resp_rdata` out 32: formatted load data; 0 for stores and errors.
- `resp_err` out 1: misaligned, reserved size, or out of range.
- `DMEM_address` out 32: word index, zero-extended.
- `DMEM_data_in` out 32: RAM write data.
- `DMEM_mem_write` out 1: RAM write strobe.
- `DMEM_mem_read` out 1: RAM read strobe.
- `DMEM_data_out` in 32: RAM read data, registered by the RAM on the falling edge.

## Operation
- Byte lanes are little-endian: lane k = bits `[8k+7:8k]`, selected by `addr[1:0]`.
- Alignment:
  - A halfword needs `addr[0]=0`.
  - A word needs `addr[1:0]=0`.
  - A violation, or `req_size=11`, produces an error response with no RAM strobe.
- States are IDLE, RD, WR and RESP. All `DMEM_*` outputs and response outputs are registered.
- IDLE, on accept:
  - Error → RESP with `resp_err=1`.
  - Load or sub-word store → RD with `DMEM_mem_read=1`.
  - Word store → WR with `DMEM_mem_write=1` and `DMEM_data_in=req_wdata`.
- RD: capture `DMEM_data_out`.
  - Load → RESP with extended lane data.
  - Sub-word store → WR with the merged word (the target lane replaced by `req_wdata[7:0]` or `[15:0]`) and `DMEM_mem_write=1`.
- WR → RESP; strobes deassert on this edge.
- RESP: `resp_valid=1`; on `resp_ready` → IDLE, `resp_valid=0`.
- Extension: byte → bit 7 replicated, or zeros when unsigned; halfword → bit 15 replicated, or zeros when unsigned.
- Request fields are latched at accept; later input changes have no effect on the operation in flight.

## Timing
- Reset values: `resp_valid=0`, `resp_rdata=0`, `resp_err=0`, all `DMEM_*=0`, state IDLE (so `req_ready=1`).
- Counting from the accept edge N:
  - Error → `resp_valid` at N+1.
  - Load → read strobe high N..N+1, response at N+2.
  - Word store → write strobe N..N+1, response at N+2.
  - Sub-word store → read N..N+1, write N+1..N+2, response at N+3.
- The RAM acts on the falling edge inside each strobe cycle. Exactly one strobe is high per cycle, never both.
- A response handshake at edge M returns to IDLE; the earliest next accept is M+1. There is no overlap of responses and requests.
- `resp_valid` stalled by `resp_ready=0`: `resp_rdata` and `resp_err` stay stable and no RAM access occurs.
- Reset mid-operation:
  - All outputs clear immediately.
  - A write strobe cleared before its falling edge drops that write.
  - The in-flight request is discarded with no response.

## Configuration
- `DMEM_LSU_BOUNDS_CHECK_EN`:
  - Defined: nonzero `req_addr[31:ADDR_WORDS_LOG2+2]` is an error (no strobe, `resp_err` at N+1).
  - Undefined: upper bits are ignored and the index wraps modulo the RAM depth.

## Test plan
- Word store 0xDEADBEEF @0x10, then word load @0x10 → `DMEM_address=4`, write strobe one cycle, load `resp_rdata=0xDEADBEEF`, `resp_err=0`.
- Byte store 0xA5 @0x11 over 0xDEADBEEF, then word load @0x10 → read cycle then write cycle with `DMEM_data_in=0xDEADA5EF`; load returns 0xDEADA5EF.
- Byte load @0x11 signed / unsigned → 0xFFFFFFA5 / 0x000000A5; halfword load @0x12 signed → 0xFFFFDEAD.
- Halfword load @0x13, word store @0x02, size 11 → `resp_err=1` at N+1, `resp_rdata=0`, no strobe ever high.
- Load with `resp_ready=0` for 5 cycles → `resp_valid` and data held, `req_ready=0`, no strobes; accept after release.
- `rst_n` low during a sub-word store WR cycle → strobes 0 immediately, memory word unchanged, `req_ready=1` after release.
- With the macro defined, load @0x400 → error at N+1. Without it, the same load returns word index 0.
